// File: rtl/bit_serializer.sv
// bit_serializer: converts parallel words into a one-bit-per-clock stream
// for the serial sequence detectors, with gapless back-to-back frames.
//
// Optional feature macro: BIT_SERIALIZER_PARITY_EN
//   defined   -> each frame carries WIDTH data bits plus one parity bit
//   undefined -> each frame is exactly WIDTH data bits, no parity logic
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   in_word    in   parallel word (WIDTH bits)
//   in_valid   in   in_word is valid
//   in_ready   out  word accepted this cycle when in_valid is high
//   data       out  serial bit to the downstream detector
//   data_valid out  data carries a real bit this cycle
//   word_done  out  one-cycle pulse on the final bit of a frame
//   busy       out  high while shifting
module bit_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned IDLE_BIT   = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data,
  output logic             data_valid,
  output logic             word_done,
  output logic             busy
);

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int unsigned F = WIDTH + 1;
`else
  localparam int unsigned F = WIDTH;
`endif
  localparam int unsigned CW = $clog2(F + 1);
  localparam logic [CW-1:0] LAST = CW'(F - 1);
  localparam logic IDLE_B = 1'(IDLE_BIT);

  // Parameter legality checks at elaboration
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("bit_serializer: WIDTH must be in 2..32");
  end
  if (PARITY_ODD > 1 || MSB_FIRST > 1 || IDLE_BIT > 1) begin : g_bad_flag
    $error("bit_serializer: PARITY_ODD, MSB_FIRST and IDLE_BIT must be 0 or 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_c;
  logic              accept_c;
  logic              head_c;
  logic              bit_c;

`ifdef BIT_SERIALIZER_PARITY_EN
  logic              par_q, par_d;
`endif

  // Frame-end and handshake decode (registered state only, plus rst/in_valid)
  assign last_c   = (state_q == ST_SHIFT) && (cnt_q == LAST);
  assign in_ready = !rst && ((state_q == ST_IDLE) || last_c);
  assign accept_c = in_valid && in_ready;

  // Current output bit: head of the shift register, or the parity bit
  assign head_c = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];
`ifdef BIT_SERIALIZER_PARITY_EN
  assign bit_c  = (cnt_q == CW'(WIDTH)) ? par_q : head_c;
`else
  assign bit_c  = head_c;
`endif

  // Outputs decoded from registered state only
  assign data       = (state_q == ST_SHIFT) ? bit_c : IDLE_B;
  assign data_valid = (state_q == ST_SHIFT);
  assign word_done  = last_c;
  assign busy       = (state_q == ST_SHIFT);

  // Next-state logic
  always_comb begin
    state_d = ST_IDLE;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
`ifdef BIT_SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = ST_SHIFT;
          cnt_d   = cnt_q + CW'(1);
          sr_d    = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, sr_q[WIDTH-1:1]};
        end
      end
      default: begin
        // Illegal encodings recover to IDLE
        state_d = ST_IDLE;
        sr_d    = '0;
        cnt_d   = '0;
      end
    endcase

    // A load overrides the above; on the last bit this gives a gapless reload
    if (accept_c) begin
      state_d = ST_SHIFT;
      sr_d    = in_word;
      cnt_d   = '0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_d   = (^in_word) ^ 1'(PARITY_ODD);
`endif
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed self-checking bench for bit_serializer
// (WIDTH=8, MSB_FIRST=1, IDLE_BIT=0, PARITY_ODD=0).
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int F = 9;
`else
  localparam int F = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_word;
  logic       in_valid;
  logic       in_ready;
  logic       data;
  logic       data_valid;
  logic       word_done;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  bit_serializer #(
    .WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(0), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready), .data(data), .data_valid(data_valid),
    .word_done(word_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected serial bit i of word w, MSB first, even parity last
  function automatic logic exp_bit(input logic [7:0] w, input int i);
    logic [7:0] v;
    v = w;
    if (i < 8) return v[7-i];
    return ^v;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_data"}, 32'(data), 32'd0);
    chk({tag, "_dv"},   32'(data_valid), 32'd0);
    chk({tag, "_wd"},   32'(word_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Checks one frame already accepted; from cnt=3 drives junk in_word and in_valid=nv,
  // and presents nxt on the last bit so it is accepted there when nv=1.
  task automatic run_frame(input logic [7:0] w, input logic nv, input logic [7:0] nxt);
    for (int i = 0; i < F; i++) begin
      chk($sformatf("data_%02h_b%0d", w, i), 32'(data), 32'(exp_bit(w, i)));
      chk($sformatf("dv_%02h_b%0d", w, i), 32'(data_valid), 32'd1);
      chk($sformatf("busy_%02h_b%0d", w, i), 32'(busy), 32'd1);
      chk($sformatf("wd_%02h_b%0d", w, i), 32'(word_done), 32'(i == F - 1));
      chk($sformatf("rdy_%02h_b%0d", w, i), 32'(in_ready), 32'(i == F - 1));
      if (i == 3) begin
        in_word  = ~w;
        in_valid = nv;
        #1;
        chk($sformatf("rdy_hold_%02h", w), 32'(in_ready), 32'd0);
      end
      if (i == F - 1) in_word = nxt;
      step();
    end
  endtask

  initial begin
    // 1. Reset
    rst = 1'b1; in_valid = 1'b0; in_word = 8'h00;
    step();
    chk("rdy_in_rst", 32'(in_ready), 32'd0);
    step();
    check_idle("rst_held");
    rst = 1'b0;
    #1;
    check_idle("post_rst");
    chk("post_rst_rdy", 32'(in_ready), 32'd1);

    // 2. Single word 0x93
    in_word = 8'h93; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    run_frame(8'h93, 1'b0, 8'h00);
    check_idle("after_93");

    // 3/4. Back-to-back 0x93 then 0x90, junk in_word mid-frame
    in_word = 8'h93; in_valid = 1'b1;
    step();
    run_frame(8'h93, 1'b1, 8'h90);
    run_frame(8'h90, 1'b0, 8'h00);
    check_idle("after_b2b");

    // 5. Reset mid-frame of 0xA5, reset beats in_valid
    in_word = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("a5_b%0d", i), 32'(data), 32'(exp_bit(8'hA5, i)));
      step();
    end
    chk("a5_b4", 32'(data), 32'd0);
    rst = 1'b1; in_valid = 1'b1; in_word = 8'hFF;
    #1;
    chk("rdy_rst_mid", 32'(in_ready), 32'd0);
    step();
    check_idle("rst_mid");
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rdy_after_mid", 32'(in_ready), 32'd1);
    step();
    check_idle("idle_after_mid");
    in_word = 8'h01; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    run_frame(8'h01, 1'b0, 8'h00);
    check_idle("after_01");

    // 6. Odd-weight word (parity bit 1 when enabled)
    in_word = 8'h91; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    run_frame(8'h91, 1'b0, 8'h00);
    check_idle("after_91");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
